// File: rtl/activate_loader.sv
// activate_loader: fetches LOAD_LEN BRAM words into a shadow buffer and commits them to act_data; ACTIVATE_LOADER_STRIDE_EN adds an addr_stride input.
module activate_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 12,
  parameter int LOAD_LEN = 9,
  parameter int MEM_LAT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_load,
  input  logic [ADDR_W-1:0]            base_addr,
`ifdef ACTIVATE_LOADER_STRIDE_EN
  input  logic [ADDR_W-1:0]            addr_stride,
`endif
  output logic                         mem_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [LOAD_LEN*DATA_W-1:0]   act_data,
  output logic                         activate_ready,
  output logic                         busy,
  output logic                         overrun
);
  localparam int CW = $clog2(LOAD_LEN + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] issue, cap;
  logic [MEM_LAT-1:0] vld;
  logic [MEM_LAT:0] vld_n;
  logic [LOAD_LEN*DATA_W-1:0] shadow, shadow_n;
  logic [ADDR_W-1:0] step;
  logic tap, accept, last_issue, last_cap;
  assign tap = vld[MEM_LAT-1];
  assign vld_n = {vld, mem_en};
  assign accept = start_load && (state == IDLE || state == DONE);
  assign last_issue = issue == CW'(LOAD_LEN);
  assign last_cap = tap && cap == CW'(LOAD_LEN - 1);
  assign busy = state == FETCH || state == DRAIN;
  assign activate_ready = state == DONE;
`ifdef ACTIVATE_LOADER_STRIDE_EN
  always_ff @(posedge clk)
    if (rst) step <= '0;
    else if (accept) step <= addr_stride;
`else
  assign step = ADDR_W'(1);
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // the word landing on the final capture edge is merged in so the commit sees a complete window
  always_comb begin
    shadow_n = shadow;
    if (tap) shadow_n[DATA_W*int'(cap) +: DATA_W] = mem_rdata;
    state_n = accept ? FETCH
            : (state == FETCH && last_issue) ? DRAIN
            : (state == DRAIN && last_cap) ? DONE
            : (state == DONE) ? IDLE
            : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
      act_data <= '0;
      overrun  <= 1'b0;
      shadow   <= '0;
      vld      <= '0;
      issue    <= '0;
      cap      <= '0;
    end else begin
      vld    <= vld_n[MEM_LAT-1:0];
      shadow <= shadow_n;
      if (tap) cap <= cap + 1'b1;
      if (accept) begin
        mem_en   <= 1'b1;
        mem_addr <= base_addr;
        issue    <= CW'(1);
        cap      <= '0;
      end else if (state == FETCH) begin
        mem_en <= !last_issue;
        if (!last_issue) begin
          mem_addr <= mem_addr + step;
          issue    <= issue + 1'b1;
        end
      end
      if (state == DRAIN && last_cap) act_data <= shadow_n;
      if (start_load && busy) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_activate_loader.sv
// tb_activate_loader: randomized bench for activate_loader against a per-load schedule model.
module tb_activate_loader;
  localparam int DW = 8, AW = 12, L = 9, M = 2, WW = L * DW;
  logic clk = 1'b0, rst = 1'b1, start_load = 1'b0;
  logic [AW-1:0] base_addr = '0;
`ifdef ACTIVATE_LOADER_STRIDE_EN
  logic [AW-1:0] addr_stride = '0;
`endif
  logic mem_en, activate_ready, busy, overrun;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, p1;
  logic [WW-1:0] act_data;
  activate_loader dut (
    .clk(clk), .rst(rst), .start_load(start_load), .base_addr(base_addr),
`ifdef ACTIVATE_LOADER_STRIDE_EN
    .addr_stride(addr_stride),
`endif
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .act_data(act_data),
    .activate_ready(activate_ready), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  // two-cycle BRAM returning the low address byte
  always @(posedge clk) begin
    p1 <= mem_addr[7:0];
    mem_rdata <= p1;
  end
  int checks = 0, failures = 0, cyc = 0, busy_from = 0, done_at = 0;
  int ecyc[$], eaddr[$], rcyc[$];
  logic [WW-1:0] rwin[$];
  logic [WW-1:0] exp_act = '0;
  logic exp_over = 1'b0;
  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  always begin : model
    int step, a;
    logic [WW-1:0] w;
    @(posedge clk);
`ifdef ACTIVATE_LOADER_STRIDE_EN
    step = int'(addr_stride);
`else
    step = 1;
`endif
    if (rst) begin
      while (ecyc.size() > 0 && ecyc[$] > cyc) begin void'(ecyc.pop_back()); void'(eaddr.pop_back()); end
      while (rcyc.size() > 0 && rcyc[$] > cyc) begin void'(rcyc.pop_back()); void'(rwin.pop_back()); end
      exp_act = '0;
      exp_over = 1'b0;
      busy_from = cyc;
      done_at = cyc;
    end else if (start_load) begin
      if (cyc >= done_at) begin
        busy_from = cyc + 1;
        done_at = cyc + 1 + L + M;
        w = '0;
        for (int i = 0; i < L; i++) begin
          a = (int'(base_addr) + i * step) % 4096;
          ecyc.push_back(cyc + 1 + i);
          eaddr.push_back(a);
          w[i*DW +: DW] = 8'(a);
        end
        rcyc.push_back(done_at);
        rwin.push_back(w);
      end else exp_over = 1'b1;
    end
    cyc++;
    @(negedge clk);
    if (ecyc.size() > 0 && ecyc[0] == cyc) begin
      check("mem_en", WW'(mem_en), WW'(1));
      check("mem_addr", WW'(mem_addr), WW'(eaddr[0]));
      void'(ecyc.pop_front());
      void'(eaddr.pop_front());
    end else check("mem_en_idle", WW'(mem_en), '0);
    if (rcyc.size() > 0 && rcyc[0] == cyc) begin
      exp_act = rwin[0];
      check("ready", WW'(activate_ready), WW'(1));
      void'(rcyc.pop_front());
      void'(rwin.pop_front());
    end else check("ready_idle", WW'(activate_ready), '0);
    check("act_data", act_data, exp_act);
    check("busy", WW'(busy), WW'(cyc >= busy_from && cyc < done_at));
    check("overrun", WW'(overrun), WW'(exp_over));
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic pulse(input logic [AW-1:0] b);
    @(posedge clk);
    #1 start_load = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1 start_load = 1'b0;
    base_addr = AW'($urandom);
  endtask
  task automatic reset_pulse();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    idle(3);
    #1 rst = 1'b0;
    check("rst_addr", WW'(mem_addr), '0);
    check("rst_act", act_data, '0);
    idle(20);
    pulse(12'h010); idle(14);
    pulse(12'hFFE); idle(14);
    pulse(12'h010); idle(3); pulse(12'h100); idle(12);
    pulse(12'h010); idle(10); pulse(12'h020); idle(24);
    pulse(12'h010); idle(4); reset_pulse();
    idle(3); pulse(12'h010); idle(14);
`ifdef ACTIVATE_LOADER_STRIDE_EN
    addr_stride = 12'd3;
    pulse(12'h000); idle(14);
    addr_stride = 12'd0;
    pulse(12'h055); idle(14);
`endif
    for (int k = 0; k < 40; k++) begin
`ifdef ACTIVATE_LOADER_STRIDE_EN
      addr_stride = AW'($urandom);
`endif
      if ($urandom_range(0, 9) == 0) reset_pulse();
      pulse(AW'($urandom_range(0, 4095)));
      idle($urandom_range(0, 14));
    end
    idle(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
